// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: arbitrates decoder writes and periodic 9-register read sweeps onto the RTC muxed bus
module rtc_bus_scheduler #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_progra,
  input  logic [7:0] add_wr,
  input  logic [7:0] data_wr,
  output logic       fin_wr,
  input  logic       refresh_req,
  output logic       sweep_busy,
  output logic       sweep_done,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD, GAP} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, addr_q, addr_d, data_q, data_d, rdat_q, rdat_d;
  logic [3:0] idx_q, idx_d;
  logic       busy_q, busy_d, wr_q, wr_d;
  logic       last, gap0, a_ph, d_ph;
  function automatic logic [7:0] sweep_addr(input logic [3:0] i);
    return (i < 4'd6) ? 8'h21 + {4'h0, i} : 8'h3b + {4'h0, i};
  endfunction
  assign last       = cnt_q == 8'(T_PHASE - 1);
  assign gap0       = state_q == GAP && cnt_q == 8'd0;
  assign a_ph       = state_q inside {A_SETUP, A_STRB, A_HOLD};
  assign d_ph       = state_q inside {D_SETUP, D_STRB, D_HOLD};
  assign fin_wr     = gap0 && wr_q;
  assign sweep_done = gap0 && !wr_q && idx_q == 4'd8;
  assign sweep_busy = busy_q && !sweep_done;
  assign rd_valid   = state_q == D_HOLD && cnt_q == 8'd0 && !wr_q;
  assign rd_addr    = addr_q;
  assign rd_data    = rdat_q;
  assign cs_n       = !(a_ph || d_ph);
  assign ad_n       = !a_ph;
  assign ad_oe      = a_ph || (d_ph && wr_q);
  assign ad_out     = a_ph ? addr_q : (d_ph && wr_q) ? data_q : 8'h00;
  assign wr_n       = !(state_q == A_STRB || (state_q == D_STRB && wr_q));
  assign rd_n       = !(state_q == D_STRB && !wr_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    wr_d    = wr_q;
    if (state_q == IDLE) begin
      if (en_progra || busy_q) begin
        state_d = A_SETUP;
        cnt_d   = 8'd0;
        wr_d    = en_progra;
        addr_d  = en_progra ? add_wr : sweep_addr(idx_q);
        data_d  = en_progra ? data_wr : data_q;
      end
    end else begin
      cnt_d = last ? 8'd0 : cnt_q + 8'd1;
      if (last) state_d = (state_q == GAP) ? IDLE : state_t'(state_q + 3'd1);
    end
    if (state_q == D_STRB && last && !wr_q) rdat_d = ad_in;
    if (gap0 && !wr_q) idx_d = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
    if (sweep_done) busy_d = 1'b0;
    // a refresh landing on the sweep_done cycle starts the next sweep
    if (refresh_req && !sweep_busy) begin
      busy_d = 1'b1;
      idx_d  = 4'd0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      rdat_q  <= 8'h00;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
    end
  end
endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: offset-based transaction model plus RTC bus model, directed scenarios
module tb_rtc_bus_scheduler;
  localparam int TP = 4;
  logic clk = 1'b0, reset = 1'b0, en_progra = 1'b0, refresh_req = 1'b0;
  logic [7:0] add_wr = 8'h00, data_wr = 8'h00, ad_in;
  logic fin_wr, sweep_busy, sweep_done, rd_valid, cs_n, ad_n, wr_n, rd_n, ad_oe;
  logic [7:0] rd_addr, rd_data, ad_out;
  int n_vec = 0, n_bad = 0, n_rdv = 0, n_done = 0;
  logic [7:0] evq[$], dq[$];
  logic [7:0] t3_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] t4_ev [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'hFF, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  rtc_bus_scheduler #(.T_PHASE(TP)) dut (
    .clk(clk), .reset(reset), .en_progra(en_progra), .add_wr(add_wr), .data_wr(data_wr),
    .fin_wr(fin_wr), .refresh_req(refresh_req), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .cs_n(cs_n), .ad_n(ad_n),
    .wr_n(wr_n), .rd_n(rd_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h21: return 8'h10; 8'h22: return 8'h11; 8'h23: return 8'h12;
      8'h24: return 8'h13; 8'h25: return 8'h14; 8'h26: return 8'h15;
      8'h41: return 8'h16; 8'h42: return 8'h17; 8'h43: return 8'h18;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] sweep_tbl(input int i);
    case (i)
      0: return 8'h21; 1: return 8'h22; 2: return 8'h23; 3: return 8'h24; 4: return 8'h25;
      5: return 8'h26; 6: return 8'h41; 7: return 8'h42; default: return 8'h43;
    endcase
  endfunction

  // RTC device: latches the address on an address-cycle strobe, returns data only while rd_n is low
  logic [7:0] rtc_a = 8'h00;
  logic [7:0] rtc_mem [256];
  bit         rtc_w [256];
  always @(posedge clk) begin
    if (!cs_n && !ad_n && !wr_n) rtc_a <= ad_out;
    if (!cs_n && ad_n && !wr_n) begin
      rtc_mem[rtc_a] <= ad_out;
      rtc_w[rtc_a]   <= 1'b1;
    end
  end
  always_comb ad_in = rd_n ? 8'hEE : rtc_w[rtc_a] ? rtc_mem[rtc_a] : init_val(rtc_a);

  // Transaction model: m_off counts clocks since the access began (0..6*TP-1 on the bus, then GAP)
  bit         m_act = 1'b0, m_wr = 1'b0, m_busy = 1'b0;
  int         m_off = 0, m_idx = 0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;
  logic [7:0] m_mem [256];
  bit         m_w [256];

  function automatic bit exp_done();
    return m_act && m_off == 6*TP && !m_wr && m_idx == 8;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    return m_w[a] ? m_mem[a] : init_val(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0; m_off <= 0; m_busy <= 1'b0; m_idx <= 0;
    end else begin
      if (!m_act) begin
        if (en_progra) begin
          m_act <= 1'b1; m_off <= 0; m_wr <= 1'b1; m_addr <= add_wr; m_data <= data_wr;
        end else if (m_busy) begin
          m_act <= 1'b1; m_off <= 0; m_wr <= 1'b0; m_addr <= sweep_tbl(m_idx);
        end
      end else begin
        if (m_off == 6*TP && m_wr) begin
          m_mem[m_addr] <= m_data; m_w[m_addr] <= 1'b1;
        end
        if (m_off == 6*TP && !m_wr) begin
          m_idx  <= (m_idx == 8) ? 0 : m_idx + 1;
          m_busy <= (m_idx == 8) ? 1'b0 : m_busy;
        end
        if (m_off == 7*TP - 1) m_act <= 1'b0;
        else m_off <= m_off + 1;
      end
      if (refresh_req && !(m_busy && !exp_done())) begin
        m_busy <= 1'b1; m_idx <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int  seg;
    bit  tx, e_rdv;
    seg   = m_off / TP;
    tx    = m_act && m_off < 6*TP;
    e_rdv = m_act && m_off == 5*TP && !m_wr;
    chk("cs_n", cs_n, !tx);
    chk("ad_n", ad_n, !(tx && seg < 3));
    chk("ad_oe", ad_oe, tx && (seg < 3 || m_wr));
    chk("wr_n", wr_n, !(tx && (seg == 1 || (seg == 4 && m_wr))));
    chk("rd_n", rd_n, !(tx && seg == 4 && !m_wr));
    chk("fin_wr", fin_wr, m_act && m_off == 6*TP && m_wr);
    chk("rd_valid", rd_valid, e_rdv);
    chk("sweep_done", sweep_done, exp_done());
    chk("sweep_busy", sweep_busy, m_busy && !exp_done());
    if (tx && (seg < 3 || m_wr)) chk("ad_out", ad_out, seg < 3 ? m_addr : m_data);
    if (e_rdv) begin
      chk("rd_addr", rd_addr, m_addr);
      chk("rd_data", rd_data, mem_rd(m_addr));
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      evq.push_back(rd_addr); dq.push_back(rd_data); n_rdv++;
    end
    if (fin_wr) evq.push_back(8'hFF);
    if (sweep_done) n_done++;
  end

  task automatic run_sweep(input int bound, input int pulse_at);
    bit got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (fin_wr) en_progra = 1'b0;
      if (k == pulse_at) refresh_req = 1'b1;
      if (k == pulse_at + 1) refresh_req = 1'b0;
      if (sweep_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("sweep_timeout", got, 1);
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh_req = 1'b1;
    @(negedge clk); refresh_req = 1'b0;
  endtask

  initial begin
    int d0, r0, cs_low, a_cnt, d_cnt, fin_k;
    bit found;
    logic [31:0] wmask;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1); chk("rst_ad_n", ad_n, 1); chk("rst_wr_n", wr_n, 1);
    chk("rst_rd_n", rd_n, 1); chk("rst_ad_oe", ad_oe, 0); chk("rst_fin", fin_wr, 0);
    chk("rst_busy", sweep_busy, 0); chk("rst_done", sweep_done, 0); chk("rst_rdv", rd_valid, 0);
    chk("rst_ad_out", ad_out, 0); chk("rst_rd_addr", rd_addr, 0); chk("rst_rd_data", rd_data, 0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    // T3: plain sweep
    evq.delete(); dq.delete(); d0 = n_done;
    pulse_refresh();
    run_sweep(600, -1);
    @(negedge clk);
    chk("t3_nreads", evq.size(), 9);
    chk("t3_ndone", n_done - d0, 1);
    for (int i = 0; i < 9 && i < evq.size(); i++) begin
      chk("t3_addr", evq[i], t3_addr[i]);
      chk("t3_data", dq[i], 8'h10 + 8'(i));
    end
    // T2: single write, timing pinned by hand
    repeat (6) @(negedge clk);
    en_progra = 1'b1; add_wr = 8'h24; data_wr = 8'h31;
    cs_low = 0; a_cnt = 0; d_cnt = 0; fin_k = 0; wmask = '0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (!cs_n) cs_low++;
      if (!cs_n && !ad_n && ad_oe && ad_out == 8'h24) a_cnt++;
      if (!cs_n && ad_n && ad_oe && ad_out == 8'h31) d_cnt++;
      if (!wr_n) wmask[k] = 1'b1;
      if (fin_wr) begin
        fin_k = k; en_progra = 1'b0;
      end
    end
    chk("t2_cs_low", cs_low, 24); chk("t2_addr_clks", a_cnt, 12); chk("t2_data_clks", d_cnt, 12);
    chk("t2_wr_mask", wmask, 32'h001E_01E0); chk("t2_fin_clk", fin_k, 25);
    // T1: reset during A_STRB of a read
    repeat (4) @(negedge clk);
    pulse_refresh();
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!cs_n && !ad_n && !wr_n) begin
        found = 1'b1;
        break;
      end
    end
    chk("t1_strobe_seen", found, 1);
    #2 reset = 1'b1;
    #1 chk("t1_cs_n", cs_n, 1); chk("t1_wr_n", wr_n, 1); chk("t1_ad_oe", ad_oe, 0);
    r0 = n_rdv;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("t1_no_reads", n_rdv - r0, 0); chk("t1_idle_busy", sweep_busy, 0);
    // T4: write arriving during read index 3
    evq.delete(); dq.delete();
    pulse_refresh();
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cs_n && !ad_n && ad_out == 8'h24) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_idx3_seen", found, 1);
    en_progra = 1'b1; add_wr = 8'h42; data_wr = 8'h77;
    run_sweep(600, -1);
    @(negedge clk);
    chk("t4_nev", evq.size(), 10);
    for (int i = 0; i < 10 && i < evq.size(); i++) chk("t4_order", evq[i], t4_ev[i]);
    if (dq.size() == 9) begin
      chk("t4_rd24", dq[3], 8'h31); chk("t4_rd42", dq[7], 8'h77);
    end else chk("t4_nreads", dq.size(), 9);
    // T5: write and refresh together, second refresh mid-sweep ignored
    repeat (6) @(negedge clk);
    evq.delete(); d0 = n_done;
    refresh_req = 1'b1; en_progra = 1'b1; add_wr = 8'h60; data_wr = 8'h5A;
    @(negedge clk); refresh_req = 1'b0;
    run_sweep(600, 100);
    repeat (300) @(negedge clk);
    chk("t5_ndone", n_done - d0, 1);
    chk("t5_nev", evq.size(), 10);
    if (evq.size() > 0) chk("t5_write_first", evq[0], 8'hFF);
    chk("t5_busy_end", sweep_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
